// File: rtl/regfile_loader.sv
// Host-driven register preloader: owns the regfile write port and holds the CPU
// in reset while a valid/ready stream of (addr, data) words is written into registers.
module regfile_loader #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              cpu_writeEnable,
  input  logic [ADDR_W-1:0] cpu_writeReg,
  input  logic [DATA_W-1:0] cpu_data_writeReg,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   load_count,
  output logic              err_r0
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] COUNT_MAX    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]      RELEASE_LAST = 4'(RELEASE_CYCLES);

  state_t              state_reg, state_next;
  logic                pend_valid_reg;
  logic [ADDR_W-1:0]   pend_addr_reg;
  logic [DATA_W-1:0]   pend_data_reg;
  logic [3:0]          drain_cnt_reg;
  logic [ADDR_W:0]     load_count_reg;
  logic                err_r0_reg;
  logic                done_reg;

  logic accept;
  logic accept_write;
  logic session_open;

  assign accept       = (state_reg == LOAD) && in_valid;
  assign accept_write = accept && (in_addr != '0);
  assign session_open = (state_reg == IDLE) && start;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = HOLD;
      HOLD:    state_next = LOAD;
      LOAD:    if (accept && in_last) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == RELEASE_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write port belongs to the CPU only while idle; otherwise the pending slot drives it.
  always_comb begin
    ctrl_writeEnable = pend_valid_reg;
    ctrl_writeReg    = pend_addr_reg;
    data_writeReg    = pend_data_reg;
    if (state_reg == IDLE) begin
      ctrl_writeEnable = cpu_writeEnable;
      ctrl_writeReg    = cpu_writeReg;
      data_writeReg    = cpu_data_writeReg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      pend_data_reg  <= '0;
      drain_cnt_reg  <= '0;
      load_count_reg <= '0;
      err_r0_reg     <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      done_reg       <= (state_reg == DRAIN) && (state_next == IDLE);
      pend_valid_reg <= accept_write;
      if (accept_write) begin
        pend_addr_reg <= in_addr;
        pend_data_reg <= in_data;
      end
      // DRAIN lasts RELEASE_CYCLES+1 cycles: the final write, then the release delay.
      drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 4'd1 : 4'd0;
      if (session_open) begin
        load_count_reg <= '0;
        err_r0_reg     <= 1'b0;
      end else begin
        if (accept_write && load_count_reg != COUNT_MAX)
          load_count_reg <= load_count_reg + 1'b1;
        if (accept && in_addr == '0)
          err_r0_reg <= 1'b1;
      end
    end
  end

  assign in_ready   = (state_reg == LOAD);
  assign busy       = (state_reg != IDLE);
  assign cpu_hold   = (state_reg != IDLE);
  assign done       = done_reg;
  assign load_count = load_count_reg;
  assign err_r0     = err_r0_reg;

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader: drives host sessions and a CPU write port,
// models the regfile behind it, and checks outputs and a final register dump.
module tb_regfile_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        cpu_writeEnable = 1'b0;
  logic [4:0]  cpu_writeReg = '0;
  logic [31:0] cpu_data_writeReg = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [5:0]  load_count;
  logic        err_r0;

  int pass_count = 0;
  int total_count = 0;

  logic [31:0] rf [32] = '{default: 32'd0};
  logic [4:0]  read_a_addr = '0;
  logic [31:0] read_a_data;
  logic [31:0] exp_rf [32] = '{default: 32'd0};

  regfile_loader #(.DATA_W(32), .ADDR_W(5), .RELEASE_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_last(in_last),
    .cpu_writeEnable(cpu_writeEnable), .cpu_writeReg(cpu_writeReg),
    .cpu_data_writeReg(cpu_data_writeReg),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .load_count(load_count), .err_r0(err_r0)
  );

  always #5 clock = ~clock;

  // Regfile stand-in: r0 hard-wired to zero, read port A combinational.
  always @(posedge clock)
    if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
  assign read_a_data = (read_a_addr == 5'd0) ? 32'd0 : rf[read_a_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic word(input logic [4:0] a, input logic [31:0] d, input logic l);
    in_valid = 1'b1; in_addr = a; in_data = d; in_last = l;
  endtask

  task automatic no_word();
    in_valid = 1'b0; in_addr = '0; in_data = '0; in_last = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clock);
  endtask

  // Pulse start from IDLE; returns at the HOLD-cycle negedge with inputs settled.
  task automatic open_session();
    cycle(); start = 1'b1; #1;
    cycle(); start = 1'b0; #1;
    check("hold_cpu_hold", 32'(cpu_hold), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(); #1;
      if (done) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic read_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    read_a_addr = a; #1;
    check(tag, read_a_data, exp);
  endtask

  initial begin
    // Reset state
    cycle(); #1;
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_r0", 32'(err_r0), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    cycle(); reset = 1'b1;

    // 1) Idle pass-through
    cycle(); cpu_writeEnable = 1'b1; cpu_writeReg = 5'd7; cpu_data_writeReg = 32'h55; #1;
    check("t1_we", 32'(ctrl_writeEnable), 32'd1);
    check("t1_reg", 32'(ctrl_writeReg), 32'd7);
    check("t1_data", data_writeReg, 32'h55);
    cycle(); cpu_writeEnable = 1'b0;
    read_reg("t1_rf7", 5'd7, 32'h55);
    exp_rf[7] = 32'h55;

    // 2) Back-to-back stream; CPU keeps trying to write r12 while held
    cycle(); start = 1'b1; #1;
    check("t2_idle_busy", 32'(busy), 32'd0);
    cycle(); start = 1'b0; cpu_writeEnable = 1'b1; cpu_writeReg = 5'd12;
    cpu_data_writeReg = 32'hbad; word(5'd1, 32'd10, 1'b0); #1;
    check("t2_hold_cpu_hold", 32'(cpu_hold), 32'd1);
    check("t2_hold_in_ready", 32'(in_ready), 32'd0);
    check("t2_hold_we", 32'(ctrl_writeEnable), 32'd0);
    check("t2_hold_busy", 32'(busy), 32'd1);
    cycle(); #1;
    check("t2_load_in_ready", 32'(in_ready), 32'd1);
    check("t2_load_we", 32'(ctrl_writeEnable), 32'd0);
    cycle(); word(5'd2, 32'd20, 1'b0); #1;
    check("t2_w1_we", 32'(ctrl_writeEnable), 32'd1);
    check("t2_w1_reg", 32'(ctrl_writeReg), 32'd1);
    check("t2_w1_data", data_writeReg, 32'd10);
    check("t2_w1_count", 32'(load_count), 32'd1);
    cycle(); word(5'd31, 32'hffffffff, 1'b1); #1;
    check("t2_w2_we", 32'(ctrl_writeEnable), 32'd1);
    check("t2_w2_reg", 32'(ctrl_writeReg), 32'd2);
    check("t2_w2_data", data_writeReg, 32'd20);
    check("t2_w2_count", 32'(load_count), 32'd2);
    cycle(); no_word(); cpu_writeEnable = 1'b0; #1;
    check("t2_w3_we", 32'(ctrl_writeEnable), 32'd1);
    check("t2_w3_reg", 32'(ctrl_writeReg), 32'd31);
    check("t2_w3_data", data_writeReg, 32'hffffffff);
    check("t2_drain_in_ready", 32'(in_ready), 32'd0);
    check("t2_drain_count", 32'(load_count), 32'd3);
    check("t2_drain_done", 32'(done), 32'd0);
    cycle(); #1;
    check("t2_drain1_we", 32'(ctrl_writeEnable), 32'd0);
    check("t2_drain1_hold", 32'(cpu_hold), 32'd1);
    cycle(); #1;
    check("t2_drain2_hold", 32'(cpu_hold), 32'd1);
    check("t2_drain2_done", 32'(done), 32'd0);
    cycle(); #1;
    check("t2_done_pulse", 32'(done), 32'd1);
    check("t2_done_hold", 32'(cpu_hold), 32'd0);
    check("t2_done_busy", 32'(busy), 32'd0);
    cycle(); #1;
    check("t2_done_clear", 32'(done), 32'd0);
    read_reg("t2_rf12_untouched", 5'd12, 32'd0);
    exp_rf[1] = 32'd10; exp_rf[2] = 32'd20; exp_rf[31] = 32'hffffffff;

    // 3) Word to r0
    open_session();
    cycle(); word(5'd0, 32'd99, 1'b0); #1;
    cycle(); word(5'd4, 32'd44, 1'b1); #1;
    check("t3_r0_we", 32'(ctrl_writeEnable), 32'd0);
    check("t3_r0_err", 32'(err_r0), 32'd1);
    check("t3_r0_count", 32'(load_count), 32'd0);
    cycle(); no_word(); #1;
    check("t3_w4_we", 32'(ctrl_writeEnable), 32'd1);
    check("t3_w4_reg", 32'(ctrl_writeReg), 32'd4);
    check("t3_w4_count", 32'(load_count), 32'd1);
    wait_done("t3_done_seen");
    check("t3_err_sticky", 32'(err_r0), 32'd1);
    exp_rf[4] = 32'd44;

    // 4) in_valid outside LOAD, gaps, and a start pulse mid-session
    cycle(); word(5'd9, 32'd90, 1'b0); #1;
    check("t4_idle_in_ready", 32'(in_ready), 32'd0);
    check("t4_idle_we", 32'(ctrl_writeEnable), 32'd0);
    cycle(); no_word(); start = 1'b1; #1;
    cycle(); start = 1'b0; #1;
    cycle(); start = 1'b1; #1;
    check("t4_load_in_ready", 32'(in_ready), 32'd1);
    check("t4_err_cleared", 32'(err_r0), 32'd0);
    check("t4_count_cleared", 32'(load_count), 32'd0);
    cycle(); start = 1'b0; word(5'd3, 32'd33, 1'b0); #1;
    check("t4_gap_we", 32'(ctrl_writeEnable), 32'd0);
    check("t4_start_ignored_busy", 32'(busy), 32'd1);
    cycle(); no_word(); #1;
    check("t4_w3_we", 32'(ctrl_writeEnable), 32'd1);
    check("t4_w3_reg", 32'(ctrl_writeReg), 32'd3);
    check("t4_w3_data", data_writeReg, 32'd33);
    cycle(); word(5'd6, 32'd66, 1'b1); #1;
    check("t4_gap2_we", 32'(ctrl_writeEnable), 32'd0);
    cycle(); no_word(); #1;
    check("t4_w6_we", 32'(ctrl_writeEnable), 32'd1);
    check("t4_w6_reg", 32'(ctrl_writeReg), 32'd6);
    check("t4_w6_count", 32'(load_count), 32'd2);
    wait_done("t4_done_seen");
    cycle(); #1;
    check("t4_after_busy", 32'(busy), 32'd0);
    check("t4_after_count", 32'(load_count), 32'd2);
    read_reg("t4_rf9_untouched", 5'd9, 32'd0);
    exp_rf[3] = 32'd33; exp_rf[6] = 32'd66;

    // 5) Reset two cycles into LOAD
    open_session();
    cycle(); word(5'd8, 32'd88, 1'b0); #1;
    cycle(); word(5'd9, 32'd99, 1'b0); #1;
    check("t5_w8_we", 32'(ctrl_writeEnable), 32'd1);
    check("t5_w8_reg", 32'(ctrl_writeReg), 32'd8);
    cycle(); #1; reset = 1'b0; no_word(); #1;
    check("t5_abort_hold", 32'(cpu_hold), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_ready", 32'(in_ready), 32'd0);
    check("t5_abort_we", 32'(ctrl_writeEnable), 32'd0);
    check("t5_abort_count", 32'(load_count), 32'd0);
    cycle(); reset = 1'b1;
    read_reg("t5_rf8", 5'd8, 32'd88);
    read_reg("t5_rf9_discarded", 5'd9, 32'd0);
    exp_rf[8] = 32'd88;
    open_session();
    cycle(); word(5'd10, 32'd100, 1'b1); #1;
    cycle(); no_word(); #1;
    check("t5_new_we", 32'(ctrl_writeEnable), 32'd1);
    check("t5_new_reg", 32'(ctrl_writeReg), 32'd10);
    check("t5_new_count", 32'(load_count), 32'd1);
    wait_done("t5_done_seen");
    exp_rf[10] = 32'd100;

    // 6) Load r5=42, release, dump every register through read port A
    open_session();
    cycle(); word(5'd5, 32'd42, 1'b1); #1;
    cycle(); no_word(); #1;
    wait_done("t6_done_seen");
    exp_rf[5] = 32'd42;
    for (int r = 0; r < 32; r++) begin
      read_a_addr = 5'(r); #1;
      check($sformatf("t6_dump_r%0d", r), read_a_data, exp_rf[r]);
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
